// File: rtl/rgb_led_controller.sv
// RGB PWM driver: debounced button mode FSM, brightness fade, period-aligned duty shadowing.
// Outputs are registered one cycle behind pwm_cnt; there is no backpressure, and duty inputs are sampled once per period.
module rgb_led_controller #(
  parameter int PWM_BITS         = 10,
  parameter int DEBOUNCE_CYCLES  = 120000,
  parameter int FADE_STEP_CYCLES = 11719
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  input  logic [PWM_BITS-1:0] duty_red,
  input  logic [PWM_BITS-1:0] duty_green,
  input  logic [PWM_BITS-1:0] duty_blue,
  output logic                led_red,
  output logic                led_green,
  output logic                led_blue,
  output logic [2:0]          mode,
  output logic                period_start,
  output logic [PWM_BITS:0]   level
);

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_FADE_IN  = 3'd1;
  localparam logic [2:0] ST_ON       = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_FADE_OUT = 3'd4;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int FT_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FT_W-1:0]     FT_LAST  = FT_W'(FADE_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
  localparam logic [PWM_BITS:0]   LVL_MAX  = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS:0]   LVL_TOP  = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS:0]   LVL_ONE  = {{PWM_BITS{1'b0}}, 1'b1};

  logic                sync_q, sync_d;
  logic                btn_s_q, btn_s_d;
  logic                btn_d_q, btn_d_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                press_q, press_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] raw_red_q, raw_red_d;
  logic [PWM_BITS-1:0] raw_green_q, raw_green_d;
  logic [PWM_BITS-1:0] raw_blue_q, raw_blue_d;
  logic [PWM_BITS-1:0] eff_red_q, eff_red_d;
  logic [PWM_BITS-1:0] eff_green_q, eff_green_d;
  logic [PWM_BITS-1:0] eff_blue_q, eff_blue_d;
  logic                led_red_q, led_red_d;
  logic                led_green_q, led_green_d;
  logic                led_blue_q, led_blue_d;
  logic [2:0]          state_q, state_d;
  logic [PWM_BITS:0]   level_q, level_d;
  logic [FT_W-1:0]     fade_cnt_q, fade_cnt_d;
  logic                fade_step;

  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] raw,
                                                input logic [PWM_BITS:0]   lvl);
    logic [2*PWM_BITS:0] prod;
    prod = {{(PWM_BITS+1){1'b0}}, raw} * {{PWM_BITS{1'b0}}, lvl};
    return PWM_BITS'(prod >> PWM_BITS);
  endfunction

  // Button: synchronize, debounce, then pulse on the accepted rising level.
  always_comb begin
    sync_d   = btn;
    btn_s_d  = sync_q;
    btn_d_d  = btn_d_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (btn_s_q != btn_d_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_d_d = btn_s_q;
        press_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Mode FSM; a press in the same cycle as a fade step wins and the step is dropped.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    fade_cnt_d = '0;
    fade_step  = (fade_cnt_q == FT_LAST);
    case (state_q)
      ST_OFF: begin
        if (press_q) state_d = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (press_q) begin
          state_d = ST_FADE_OUT;
        end else if (fade_step) begin
          if (level_q >= LVL_TOP) begin
            level_d = LVL_MAX;
            state_d = ST_ON;
          end else begin
            level_d = level_q + 1'b1;
          end
        end else begin
          fade_cnt_d = fade_cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (press_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (press_q) state_d = ST_FADE_OUT;
      end
      ST_FADE_OUT: begin
        if (press_q) begin
          state_d = ST_FADE_IN;
        end else if (fade_step) begin
          if (level_q <= LVL_ONE) begin
            level_d = '0;
            state_d = ST_OFF;
          end else begin
            level_d = level_q - 1'b1;
          end
        end else begin
          fade_cnt_d = fade_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        level_d = '0;
      end
    endcase
  end

  // Shadow registers update only on the last count so a period never mixes old and new duty.
  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    raw_red_d   = raw_red_q;
    raw_green_d = raw_green_q;
    raw_blue_d  = raw_blue_q;
    eff_red_d   = eff_red_q;
    eff_green_d = eff_green_q;
    eff_blue_d  = eff_blue_q;
    if (pwm_cnt_q == CNT_LAST) begin
      if (state_q != ST_HOLD) begin
        raw_red_d   = duty_red;
        raw_green_d = duty_green;
        raw_blue_d  = duty_blue;
      end
      eff_red_d   = scale(raw_red_d, level_d);
      eff_green_d = scale(raw_green_d, level_d);
      eff_blue_d  = scale(raw_blue_d, level_d);
    end
    led_red_d   = (pwm_cnt_q < eff_red_q);
    led_green_d = (pwm_cnt_q < eff_green_q);
    led_blue_d  = (pwm_cnt_q < eff_blue_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 1'b0;
      btn_s_q     <= 1'b0;
      btn_d_q     <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      pwm_cnt_q   <= '0;
      raw_red_q   <= '0;
      raw_green_q <= '0;
      raw_blue_q  <= '0;
      eff_red_q   <= '0;
      eff_green_q <= '0;
      eff_blue_q  <= '0;
      led_red_q   <= 1'b0;
      led_green_q <= 1'b0;
      led_blue_q  <= 1'b0;
      state_q     <= ST_OFF;
      level_q     <= '0;
      fade_cnt_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      btn_s_q     <= btn_s_d;
      btn_d_q     <= btn_d_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      pwm_cnt_q   <= pwm_cnt_d;
      raw_red_q   <= raw_red_d;
      raw_green_q <= raw_green_d;
      raw_blue_q  <= raw_blue_d;
      eff_red_q   <= eff_red_d;
      eff_green_q <= eff_green_d;
      eff_blue_q  <= eff_blue_d;
      led_red_q   <= led_red_d;
      led_green_q <= led_green_d;
      led_blue_q  <= led_blue_d;
      state_q     <= state_d;
      level_q     <= level_d;
      fade_cnt_q  <= fade_cnt_d;
    end
  end

  assign led_red      = led_red_q;
  assign led_green    = led_green_q;
  assign led_blue     = led_blue_q;
  assign mode         = state_q;
  assign level        = level_q;
  assign period_start = (pwm_cnt_q == '0);

endmodule

// File: tb/tb_rgb_led_controller.sv
// Directed bench for rgb_led_controller with short debounce/fade constants.
module tb_rgb_led_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [9:0]  duty_red, duty_green, duty_blue;
  logic        led_red, led_green, led_blue;
  logic [2:0]  mode;
  logic        period_start;
  logic [10:0] level;

  int total = 0;
  int bad   = 0;

  rgb_led_controller #(
    .PWM_BITS(10),
    .DEBOUNCE_CYCLES(4),
    .FADE_STEP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .duty_red(duty_red),
    .duty_green(duty_green),
    .duty_blue(duty_blue),
    .led_red(led_red),
    .led_green(led_green),
    .led_blue(led_blue),
    .mode(mode),
    .period_start(period_start),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_period();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < 1100);
    total++;
    if (!period_start) begin
      bad++;
      $display("FAIL period_sync got=period_start low for %0d cycles exp=pulse within 1024", n);
    end
  endtask

  task automatic press_btn();
    btn = 1'b1;
    repeat (7) tick();
    btn = 1'b0;
  endtask

  task automatic count_period(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (1024) begin
      tick();
      r += int'(led_red);
      g += int'(led_green);
      b += int'(led_blue);
    end
  endtask

  task automatic test_reset();
    int pulses, first_p, second_p, led_hi, bad_state;
    rst = 1'b1;
    btn = 1'b0;
    tick();
    tick();
    total++; if (mode !== 3'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    total++; if (level !== 11'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if ({led_red, led_green, led_blue} !== 3'b000) begin bad++; $display("FAIL reset_leds got=%b exp=000", {led_red, led_green, led_blue}); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL reset_period_start got=%b exp=1", period_start); end
    rst = 1'b0;
    pulses = 0; first_p = -1; second_p = -1; led_hi = 0; bad_state = 0;
    for (int i = 1; i <= 2048; i++) begin
      tick();
      if (period_start === 1'b1) begin
        pulses++;
        if (pulses == 1) first_p = i;
        if (pulses == 2) second_p = i;
      end
      if ({led_red, led_green, led_blue} !== 3'b000) led_hi++;
      if (mode !== 3'd0 || level !== 11'd0) bad_state++;
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL idle_pulse_count got=%0d exp=2", pulses); end
    total++; if (first_p != 1024 || second_p != 2048) begin bad++; $display("FAIL idle_pulse_pos got=%0d,%0d exp=1024,2048", first_p, second_p); end
    total++; if (led_hi != 0) begin bad++; $display("FAIL idle_leds got=%0d lit cycles exp=0", led_hi); end
    total++; if (bad_state != 0) begin bad++; $display("FAIL idle_state got=%0d bad cycles exp=0", bad_state); end
  endtask

  task automatic test_debounce();
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (12) tick();
    total++; if (mode !== 3'd0) begin bad++; $display("FAIL glitch_mode got=%0d exp=0", mode); end
    btn = 1'b1;
    repeat (6) tick();
    total++; if (mode !== 3'd0) begin bad++; $display("FAIL press_edge6_mode got=%0d exp=0", mode); end
    tick();
    total++; if (mode !== 3'd1) begin bad++; $display("FAIL press_edge7_mode got=%0d exp=1", mode); end
    total++; if (level !== 11'd0) begin bad++; $display("FAIL fade_in_entry_level got=%0d exp=0", level); end
  endtask

  task automatic test_fade_in();
    tick();
    total++; if (level !== 11'd0) begin bad++; $display("FAIL fade_in_t1 got=%0d exp=0", level); end
    tick();
    total++; if (level !== 11'd1) begin bad++; $display("FAIL fade_in_t2 got=%0d exp=1", level); end
    tick();
    btn = 1'b0;
    repeat (2044) tick();
    total++; if (mode !== 3'd1 || level !== 11'd1023) begin bad++; $display("FAIL fade_in_t2047 got=mode %0d level %0d exp=mode 1 level 1023", mode, level); end
    tick();
    total++; if (mode !== 3'd2 || level !== 11'd1024) begin bad++; $display("FAIL fade_in_done got=mode %0d level %0d exp=mode 2 level 1024", mode, level); end
  endtask

  task automatic test_on_pwm();
    int r, g, b;
    wait_period();
    count_period(r, g, b);
    total++; if (r != 512) begin bad++; $display("FAIL on_red_count got=%0d exp=512", r); end
    total++; if (g != 100) begin bad++; $display("FAIL on_green_count got=%0d exp=100", g); end
    total++; if (b != 1023) begin bad++; $display("FAIL on_blue_count got=%0d exp=1023", b); end
  endtask

  task automatic test_hold();
    int r, g, b, n;
    press_btn();
    total++; if (mode !== 3'd3) begin bad++; $display("FAIL hold_mode got=%0d exp=3", mode); end
    duty_green = 10'd900;
    wait_period();
    count_period(r, g, b);
    total++; if (g != 100) begin bad++; $display("FAIL hold_green_count got=%0d exp=100", g); end
    total++; if (r != 512) begin bad++; $display("FAIL hold_red_count got=%0d exp=512", r); end
    total++; if (level !== 11'd1024) begin bad++; $display("FAIL hold_level got=%0d exp=1024", level); end
    press_btn();
    total++; if (mode !== 3'd4 || level !== 11'd1024) begin bad++; $display("FAIL fade_out_entry got=mode %0d level %0d exp=mode 4 level 1024", mode, level); end
    tick();
    tick();
    total++; if (level !== 11'd1023) begin bad++; $display("FAIL fade_out_first_step got=%0d exp=1023", level); end
    n = 0;
    while (mode !== 3'd0 && n < 2100) begin
      tick();
      n++;
    end
    total++; if (mode !== 3'd0 || level !== 11'd0) begin bad++; $display("FAIL fade_out_end got=mode %0d level %0d after %0d cycles exp=mode 0 level 0", mode, level, n); end
    total++; if (n != 2046) begin bad++; $display("FAIL fade_out_length got=%0d exp=2046", n); end
  endtask

  task automatic test_press_priority();
    int n;
    press_btn();
    total++; if (mode !== 3'd1 || level !== 11'd0) begin bad++; $display("FAIL prio_entry got=mode %0d level %0d exp=mode 1 level 0", mode, level); end
    repeat (595) tick();
    total++; if (level !== 11'd297) begin bad++; $display("FAIL prio_level_pre got=%0d exp=297", level); end
    press_btn();
    total++; if (mode !== 3'd4 || level !== 11'd300) begin bad++; $display("FAIL prio_switch got=mode %0d level %0d exp=mode 4 level 300", mode, level); end
    tick();
    total++; if (level !== 11'd300) begin bad++; $display("FAIL prio_hold_level got=%0d exp=300", level); end
    tick();
    total++; if (level !== 11'd299) begin bad++; $display("FAIL prio_first_down got=%0d exp=299", level); end
    n = 0;
    while (mode !== 3'd0 && n < 700) begin
      tick();
      n++;
    end
    total++; if (mode !== 3'd0 || level !== 11'd0) begin bad++; $display("FAIL prio_reach_off got=mode %0d level %0d exp=mode 0 level 0", mode, level); end
  endtask

  task automatic test_scaling();
    int r, g, b;
    wait_period();
    repeat (1017) tick();
    press_btn();
    total++; if (mode !== 3'd1 || period_start !== 1'b1) begin bad++; $display("FAIL scale_align got=mode %0d ps %b exp=mode 1 ps 1", mode, period_start); end
    repeat (1024) tick();
    total++; if (level !== 11'd512 || period_start !== 1'b1) begin bad++; $display("FAIL scale_level got=level %0d ps %b exp=level 512 ps 1", level, period_start); end
    count_period(r, g, b);
    total++; if (b != 511) begin bad++; $display("FAIL scale_blue got=%0d exp=511", b); end
    total++; if (r != 256) begin bad++; $display("FAIL scale_red got=%0d exp=256", r); end
    total++; if (g != 450) begin bad++; $display("FAIL scale_green got=%0d exp=450", g); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (mode !== 3'd2 && n < 100) begin
      tick();
      n++;
    end
    total++; if (mode !== 3'd2) begin bad++; $display("FAIL mid_reach_on got=%0d exp=2", mode); end
    press_btn();
    total++; if (mode !== 3'd3) begin bad++; $display("FAIL mid_hold got=%0d exp=3", mode); end
    wait_period();
    repeat (700) tick();
    total++; if (led_blue !== 1'b1 || led_red !== 1'b0) begin bad++; $display("FAIL mid_pre_leds got=r%b b%b exp=r0 b1", led_red, led_blue); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (mode !== 3'd0 || level !== 11'd0) begin bad++; $display("FAIL mid_reset_state got=mode %0d level %0d exp=mode 0 level 0", mode, level); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL mid_reset_pwm got=ps %b exp=1", period_start); end
    total++; if ({led_red, led_green, led_blue} !== 3'b000) begin bad++; $display("FAIL mid_reset_leds got=%b exp=000", {led_red, led_green, led_blue}); end
    repeat (20) tick();
    total++; if (mode !== 3'd0 || level !== 11'd0 || period_start !== 1'b0) begin bad++; $display("FAIL mid_after_reset got=mode %0d level %0d ps %b exp=mode 0 level 0 ps 0", mode, level, period_start); end
  endtask

  initial begin
    rst        = 1'b1;
    btn        = 1'b0;
    duty_red   = 10'd512;
    duty_green = 10'd100;
    duty_blue  = 10'd1023;
    test_reset();
    test_debounce();
    test_fade_in();
    test_on_pwm();
    test_hold();
    test_press_priority();
    test_scaling();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
